commit_trap_tracker: RTL

- Sits directly upstream of the simulation trap monitor.
- Watches the commit stage and produces the signals that monitor consumes: trap flag, trap code, trap PC, cycle count and committed-instruction count.
- Detects the first committed trap instruction and latches its code and PC, then freezes the counters.
- Raises a synthetic timeout trap if nothing commits for too long.

---
 rtl/commit_trap_pkg.sv | 16 +
 rtl/commit_slot_scan.sv | 59 +++++
 rtl/commit_trap_tracker.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/commit_trap_pkg.sv
// commit_trap_pkg
//   Shared types and constants for the commit-stage trap tracker.
//   - trap_state_e     : tracker state (RUN until a trap is latched, then TRAPPED)
//   - CNT_W            : width of the cycle / instruction counters
//   - TIMEOUT_CODE_DEF : trap code reported when the no-commit watchdog fires
package commit_trap_pkg;

    localparam int unsigned CNT_W            = 32;
    localparam logic [31:0] TIMEOUT_CODE_DEF = 32'h0000_0003;

    typedef enum logic {
        RUN     = 1'b0,
        TRAPPED = 1'b1
    } trap_state_e;

endpackage

// File: rtl/commit_slot_scan.sv
// commit_slot_scan
//   Combinational scan of the commit slots for one cycle. Slot 0 is oldest.
//   The oldest valid trap instruction terminates the commit group: it and
//   every older valid slot are effective, younger slots are dropped.
//   Ports:
//     commit_valid_i   per-slot commit valid
//     commit_is_trap_i per-slot trap flag (only meaningful with valid)
//     trap_hit_o       some valid slot is a trap instruction
//     trap_idx_o       index of the oldest valid trap slot
//     eff_mask_o       slots whose commit actually takes effect
//     eff_popcount_o   number of set bits in eff_mask_o
//     youngest_idx_o   index of the youngest effective slot
module commit_slot_scan #(
    parameter  int unsigned COMMIT_WIDTH = 2,
    localparam int unsigned IDX_W        = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1,
    localparam int unsigned PCNT_W       = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic [COMMIT_WIDTH-1:0] commit_valid_i,
    input  logic [COMMIT_WIDTH-1:0] commit_is_trap_i,
    output logic                    trap_hit_o,
    output logic [IDX_W-1:0]        trap_idx_o,
    output logic [COMMIT_WIDTH-1:0] eff_mask_o,
    output logic [PCNT_W-1:0]       eff_popcount_o,
    output logic [IDX_W-1:0]        youngest_idx_o
);

    logic                    hit;
    logic [IDX_W-1:0]        hit_idx;
    logic [COMMIT_WIDTH-1:0] mask;
    logic [PCNT_W-1:0]       pcnt;
    logic [IDX_W-1:0]        yidx;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        mask    = '0;
        pcnt    = '0;
        yidx    = '0;
        for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
            // Once a trap is seen, every younger slot is squashed.
            if (commit_valid_i[i] && !hit) begin
                mask[i] = 1'b1;
                pcnt    = pcnt + PCNT_W'(1);
                yidx    = IDX_W'(i);
                if (commit_is_trap_i[i]) begin
                    hit     = 1'b1;
                    hit_idx = IDX_W'(i);
                end
            end
        end
    end

    assign trap_hit_o     = hit;
    assign trap_idx_o     = hit_idx;
    assign eff_mask_o     = mask;
    assign eff_popcount_o = pcnt;
    assign youngest_idx_o = yidx;

endmodule

// File: rtl/commit_trap_tracker.sv
// commit_trap_tracker
//   Watches the commit stage, counts RUN cycles and committed instructions,
//   and latches the first trap (software trap instruction or no-commit
//   watchdog timeout). After a trap everything freezes until reset.
//   Ports:
//     clk_i, reset_n_i   clock; synchronous active-low reset
//     commit_valid_i     per-slot commit valid (slot 0 oldest)
//     commit_pc_i        per-slot PC, slot i at [i*PC_WIDTH +: PC_WIDTH]
//     commit_is_trap_i   per-slot trap-instruction flag
//     trap_value_i       software trap code, sampled in the trap cycle
//     is_noop_trap_o     high once a trap is latched
//     trap_code_o        latched trap code (0 while running)
//     trap_pc_o          latched trap PC, low 32 bits (0 while running)
//     cycle_cnt_o        RUN cycles including the trap cycle
//     instr_cnt_o        effective commits including the trap instruction
module commit_trap_tracker
    import commit_trap_pkg::*;
#(
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned PC_WIDTH     = 39,
    parameter int unsigned TIMEOUT      = 5000,
    parameter logic [31:0] TIMEOUT_CODE = TIMEOUT_CODE_DEF
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [COMMIT_WIDTH-1:0]      commit_valid_i,
    input  logic [COMMIT_WIDTH*PC_WIDTH-1:0] commit_pc_i,
    input  logic [COMMIT_WIDTH-1:0]      commit_is_trap_i,
    input  logic [31:0]                  trap_value_i,
    output logic                         is_noop_trap_o,
    output logic [31:0]                  trap_code_o,
    output logic [31:0]                  trap_pc_o,
    output logic [CNT_W-1:0]             cycle_cnt_o,
    output logic [CNT_W-1:0]             instr_cnt_o
);

    localparam int unsigned IDX_W  = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;
    localparam int unsigned PCNT_W = $clog2(COMMIT_WIDTH + 1);
    localparam int unsigned EXT_W  = (PC_WIDTH > 32) ? PC_WIDTH : 32;
    // Idle count at which the current idle cycle becomes the timeout cycle.
    localparam logic [31:0] IDLE_LIMIT = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    // Low 32 bits of each slot PC (zero-extended if PC_WIDTH < 32).
    logic [COMMIT_WIDTH-1:0][31:0] pc_lo;

    for (genvar g = 0; g < COMMIT_WIDTH; g++) begin : g_pc
        logic [EXT_W-1:0] ext;
        logic             unused_pc_hi;
        assign ext          = EXT_W'(commit_pc_i[g*PC_WIDTH +: PC_WIDTH]);
        assign pc_lo[g]     = ext[31:0];
        assign unused_pc_hi = ^ext;
    end

    logic                    trap_hit;
    logic [IDX_W-1:0]        trap_idx;
    logic [COMMIT_WIDTH-1:0] eff_mask;
    logic [PCNT_W-1:0]       eff_popcount;
    logic [IDX_W-1:0]        youngest_idx;

    commit_slot_scan #(
        .COMMIT_WIDTH(COMMIT_WIDTH)
    ) u_scan (
        .commit_valid_i  (commit_valid_i),
        .commit_is_trap_i(commit_is_trap_i),
        .trap_hit_o      (trap_hit),
        .trap_idx_o      (trap_idx),
        .eff_mask_o      (eff_mask),
        .eff_popcount_o  (eff_popcount),
        .youngest_idx_o  (youngest_idx)
    );

    trap_state_e     state_q, state_d;
    logic [31:0]     trap_code_q, trap_code_d;
    logic [31:0]     trap_pc_q, trap_pc_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [31:0]     last_pc_q, last_pc_d;
    logic [31:0]     idle_q, idle_d;

    logic any_commit;
    logic timeout_hit;

    // The oldest valid slot is always effective, so this equals |commit_valid_i.
    assign any_commit  = |eff_mask;
    assign timeout_hit = (TIMEOUT != 0) && !any_commit && (idle_q == IDLE_LIMIT);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= RUN;
            trap_code_q <= '0;
            trap_pc_q   <= '0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
            last_pc_q   <= '0;
            idle_q      <= '0;
        end else begin
            state_q     <= state_d;
            trap_code_q <= trap_code_d;
            trap_pc_q   <= trap_pc_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
            last_pc_q   <= last_pc_d;
            idle_q      <= idle_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        trap_code_d = trap_code_q;
        trap_pc_d   = trap_pc_q;
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        last_pc_d   = last_pc_q;
        idle_d      = idle_q;
        case (state_q)
            RUN: begin
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                instr_cnt_d = instr_cnt_q + CNT_W'(eff_popcount);
                if (any_commit) begin
                    last_pc_d = pc_lo[youngest_idx];
                    idle_d    = '0;
                end else if (idle_q != '1) begin
                    idle_d = idle_q + 32'd1;
                end
                // A timeout needs an empty cycle, so it never races a trap commit.
                if (trap_hit) begin
                    state_d     = TRAPPED;
                    trap_code_d = trap_value_i;
                    trap_pc_d   = pc_lo[trap_idx];
                end else if (timeout_hit) begin
                    state_d     = TRAPPED;
                    trap_code_d = TIMEOUT_CODE;
                    trap_pc_d   = last_pc_q;
                end
            end
            TRAPPED: begin
                state_d = TRAPPED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign is_noop_trap_o = (state_q == TRAPPED);
    assign trap_code_o    = trap_code_q;
    assign trap_pc_o      = trap_pc_q;
    assign cycle_cnt_o    = cycle_cnt_q;
    assign instr_cnt_o    = instr_cnt_q;

endmodule
